// File: rtl/databus_axi_burst_if.sv
// Bus bundle between the native databus port and the AXI4 master side.
// master: the burst converter; slave: upstream merger plus AXI interconnect.
interface databus_axi_burst_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 256,
   parameter int LEN_W  = 8
);
   // native databus side
   logic                databus_valid;
   logic [ADDR_W-1:0]   databus_addr;
   logic [DATA_W-1:0]   databus_wdata;
   logic [DATA_W/8-1:0] databus_wstrb;
   logic                databus_ready;
   logic [DATA_W-1:0]   databus_rdata;
   logic [LEN_W-1:0]    dma_len;

   // AXI write address / data / response
   logic [ADDR_W-1:0]   m_axi_awaddr;
   logic [LEN_W-1:0]    m_axi_awlen;
   logic [2:0]          m_axi_awsize;
   logic [1:0]          m_axi_awburst;
   logic                m_axi_awvalid;
   logic                m_axi_awready;
   logic [DATA_W-1:0]   m_axi_wdata;
   logic [DATA_W/8-1:0] m_axi_wstrb;
   logic                m_axi_wlast;
   logic                m_axi_wvalid;
   logic                m_axi_wready;
   logic [1:0]          m_axi_bresp;
   logic                m_axi_bvalid;
   logic                m_axi_bready;

   // AXI read address / data
   logic [ADDR_W-1:0]   m_axi_araddr;
   logic [LEN_W-1:0]    m_axi_arlen;
   logic [2:0]          m_axi_arsize;
   logic [1:0]          m_axi_arburst;
   logic                m_axi_arvalid;
   logic                m_axi_arready;
   logic [DATA_W-1:0]   m_axi_rdata;
   logic [1:0]          m_axi_rresp;
   logic                m_axi_rlast;
   logic                m_axi_rvalid;
   logic                m_axi_rready;

   modport master (
      input  databus_valid, databus_addr, databus_wdata, databus_wstrb, dma_len,
      output databus_ready, databus_rdata,
      output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
      input  m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      input  m_axi_wready,
      input  m_axi_bresp, m_axi_bvalid,
      output m_axi_bready,
      output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
      input  m_axi_arready,
      input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      output m_axi_rready
   );

   modport slave (
      output databus_valid, databus_addr, databus_wdata, databus_wstrb, dma_len,
      input  databus_ready, databus_rdata,
      input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
      output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      output m_axi_wready,
      output m_axi_bresp, m_axi_bvalid,
      input  m_axi_bready,
      input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
      output m_axi_arready,
      output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      input  m_axi_rready
   );
endinterface

// File: rtl/databus_axi_burst.sv
// Native databus to AXI4 INCR burst converter, one outstanding burst.
// Direction is taken from the first beat's wstrb; address and length are
// latched on that beat and held for the whole burst.
// Optional macro DMA_RESP_CHECK_EN: sticky error on non-OKAY responses and
// on rlast disagreeing with the beat count. Without it, error is tied low.
module databus_axi_burst #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 256,
   parameter int LEN_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   databus_axi_burst_if.master bus,
   output logic                busy,
   output logic                error
);
   localparam int SIZE = $clog2(DATA_W/8);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] RADDR = 3'd1;
   localparam logic [2:0] RDATA = 3'd2;
   localparam logic [2:0] WADDR = 3'd3;
   localparam logic [2:0] WDATA = 3'd4;
   localparam logic [2:0] WRESP = 3'd5;

   logic [2:0]        state;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt;
   logic              last_beat;
   logic              r_hs;
   logic              w_hs;

   // low address bits are dropped by alignment
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^bus.databus_addr[SIZE-1:0];

   assign last_beat = (cnt == len_q);
   assign r_hs = (state == RDATA) && bus.m_axi_rvalid && bus.databus_valid;
   assign w_hs = (state == WDATA) && bus.m_axi_wready && bus.databus_valid;

   // burst sequencing: latch request, address phase, beat counting, response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         addr_q <= '0;
         len_q  <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.databus_valid) begin
                  addr_q <= {bus.databus_addr[ADDR_W-1:SIZE], {SIZE{1'b0}}};
                  len_q  <= bus.dma_len;
                  cnt    <= '0;
                  state  <= (|bus.databus_wstrb) ? WADDR : RADDR;
               end
            end
            RADDR: begin
               if (bus.m_axi_arready) begin
                  cnt   <= '0;
                  state <= RDATA;
               end
            end
            RDATA: begin
               if (r_hs) begin
                  if (last_beat) state <= IDLE;
                  else           cnt   <= cnt + LEN_W'(1);
               end
            end
            WADDR: begin
               if (bus.m_axi_awready) begin
                  cnt   <= '0;
                  state <= WDATA;
               end
            end
            WDATA: begin
               if (w_hs) begin
                  if (last_beat) state <= WRESP;
                  else           cnt   <= cnt + LEN_W'(1);
               end
            end
            WRESP: begin
               if (bus.m_axi_bvalid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.m_axi_awaddr  = addr_q;
   assign bus.m_axi_awlen   = len_q;
   assign bus.m_axi_awsize  = 3'(SIZE);
   assign bus.m_axi_awburst = 2'b01;
   assign bus.m_axi_awvalid = (state == WADDR);

   // write data passes straight through; valid follows the upstream beat
   assign bus.m_axi_wdata   = bus.databus_wdata;
   assign bus.m_axi_wstrb   = bus.databus_wstrb;
   assign bus.m_axi_wvalid  = (state == WDATA) && bus.databus_valid;
   assign bus.m_axi_wlast   = (state == WDATA) && last_beat;
   assign bus.m_axi_bready  = (state == WRESP);

   assign bus.m_axi_araddr  = addr_q;
   assign bus.m_axi_arlen   = len_q;
   assign bus.m_axi_arsize  = 3'(SIZE);
   assign bus.m_axi_arburst = 2'b01;
   assign bus.m_axi_arvalid = (state == RADDR);
   assign bus.m_axi_rready  = (state == RDATA) && bus.databus_valid;

   assign bus.databus_rdata = bus.m_axi_rdata;
   assign bus.databus_ready = r_hs || w_hs;
   assign busy              = (state != IDLE);

`ifdef DMA_RESP_CHECK_EN
   // sticky error: bad read/write response or rlast out of step with the count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         error <= 1'b0;
      end else if ((r_hs && ((bus.m_axi_rresp != 2'b00) || (bus.m_axi_rlast != last_beat))) ||
                   ((state == WRESP) && bus.m_axi_bvalid && (bus.m_axi_bresp != 2'b00))) begin
         error <= 1'b1;
      end
   end
`else
   logic unused_resp;
   assign unused_resp = ^{bus.m_axi_rresp, bus.m_axi_bresp, bus.m_axi_rlast};
   assign error       = 1'b0;
`endif

endmodule

// File: doc/databus_axi_burst.md
Name: databus_axi_burst

Overview:
- Downstream of the Versat datapath. Converts one native databus request port (valid/addr/wdata/wstrb/ready/rdata plus dma_len) into AXI4 INCR bursts toward the DDR interconnect.
- The upstream merger presents one port at a time and holds dma_len stable for the whole burst.
- Direction comes from the first beat: wstrb != 0 is a write burst, otherwise a read burst.
- One outstanding burst at a time.

Parameters:
ADDR_W, 32, byte address width on both sides
DATA_W, 256, databus and AXI data width (power of 2, >= 32)
LEN_W, 8, burst length field width (AXI len = beats-1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
databus_valid  in  1  native beat request
databus_addr  in  ADDR_W  byte address; sampled only on the first beat of a burst
databus_wdata  in  DATA_W  write beat data
databus_wstrb  in  DATA_W/8  byte enables; nonzero = write
databus_ready  out  1  beat accepted (write) / beat data valid (read)
databus_rdata  out  DATA_W  read beat data
dma_len  in  LEN_W  beats-1 of the burst
m_axi_awaddr/awlen/awsize/awburst/awvalid  out  ADDR_W/LEN_W/3/2/1  AXI write address
m_axi_awready  in  1
m_axi_wdata/wstrb/wlast/wvalid  out  DATA_W/DATA_W/8/1/1  AXI write data
m_axi_wready  in  1
m_axi_bresp/bvalid  in  2/1;  m_axi_bready  out  1
m_axi_araddr/arlen/arsize/arburst/arvalid  out  ADDR_W/LEN_W/3/2/1  AXI read address
m_axi_arready  in  1
m_axi_rdata/rresp/rlast/rvalid  in  DATA_W/2/1/1;  m_axi_rready  out  1
busy  out  1  state != IDLE
error  out  1  sticky response/protocol error

Behaviour:
- Reset: state IDLE; all valid/ready/last outputs 0; addr/len registers 0; busy 0; error 0.
- awsize/arsize = log2(DATA_W/8); awburst/arburst = 2'b01 (INCR), constant.
- Address is aligned by zeroing the low log2(DATA_W/8) bits.
- IDLE, databus_valid=1:
  - Latch aligned addr and dma_len.
  - Go to WADDR if |databus_wstrb, else RADDR.
  - databus_ready stays 0 in this cycle.
- RADDR: arvalid=1; araddr/arlen from latched registers, held stable until arready. On arready -> RDATA, beat counter cnt=0.
- RDATA:
  - rready = databus_valid; databus_rdata = m_axi_rdata (combinational).
  - databus_ready = rvalid & databus_valid.
  - On each handshake cnt++. At cnt==len handshake -> IDLE.
  - If rlast disagrees with cnt==len, still -> IDLE on cnt==len (see feature).
- WADDR: awvalid=1, held until awready -> WDATA, cnt=0.
- WDATA:
  - wvalid = databus_valid; wdata/wstrb pass through.
  - wlast = (cnt==len); databus_ready = wready & databus_valid.
  - On each handshake cnt++. Handshake at cnt==len -> WRESP.
- WRESP: bready=1; on bvalid -> IDLE. databus_ready=0 meanwhile, so a new request waits.
- Latency: read first beat ≥2 cycles after request plus slave latency. Back-to-back beats at 1/cycle when both sides are ready.
- dma_len=0: single-beat burst, awlen/arlen=0, wlast=1 on the only beat.
- databus_valid dropping mid-burst: AXI valid/ready follow it (stall). No abort; the burst completes when valid resumes.
- Changes to databus_addr/dma_len mid-burst are ignored.
- 4 KB boundary crossing is not checked; software guarantees it.
- rst mid-burst: immediate return to IDLE, all AXI valids 0 asynchronously. Interconnect is reset by the same rst.

Optional Feature:
DMA_RESP_CHECK_EN
- Defined: error is set (sticky until rst) on any of:
  - rresp != 2'b00 on a read handshake
  - bresp != 2'b00 on bvalid
  - rlast=1 with cnt!=len
  - rlast=0 with cnt==len
- Not defined: error tied to 0; rresp/bresp ignored; no check logic.

Test Plan:
- Read, addr=0x1010, dma_len=3; slave always ready; rdata=beat index. Expect:
  - araddr=0x1000, arlen=3, arsize=5, arburst=1;
  - 4 databus_ready pulses with rdata 0..3;
  - busy low 1 cycle after the 4th beat.
- Write, addr=0x2000, dma_len=7, wstrb all-1; wready toggled every other cycle. Expect:
  - 8 W handshakes, wlast only on the 8th;
  - awlen=7;
  - IDLE only after bvalid.
- dma_len=0 read and write. Expect single beat with rlast/wlast=1 and arlen/awlen=0.
- Read dma_len=3, databus_valid deasserted 3 cycles after beat 1. Expect:
  - rready=0 during the gap;
  - no lost or duplicated beats;
  - 4 total handshakes.
- Async rst asserted mid write burst (beat 2 of 4). Expect:
  - awvalid/wvalid/busy/error 0 immediately;
  - the next request starts a fresh burst at the new address.
- With DMA_RESP_CHECK_EN: bresp=2'b10 on a write. Expect error=1, held across later OKAY bursts until rst. Without the macro, error stays 0.
